// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: sequential WIDTH-bit adder built from one 2-bit adder slice.
// Operands are accepted on a valid/ready handshake and consumed two bits per
// cycle, LSB chunk first, with the carry held in a register between chunks.
// The result is presented on a second valid/ready handshake.
// Optional feature: define ADD_SEQ_SUB_EN to add a 'sub' input. When sub is
// set, the block computes a-b in two's complement (invert b, carry-in of 1).
module add_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ADD_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
);

  localparam int CHUNKS = WIDTH / 2;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     sum_q;
  logic [2:0]         slice;
  logic [WIDTH+1:0]   sum_shift;
  logic               accept;
  logic               last_chunk;
  logic [WIDTH-1:0]   b_load;
  logic               carry_init;

  // The 2+2+1 -> 3-bit slice adder shared by every chunk.
  function automatic logic [2:0] add_slice(input logic [1:0] x,
                                           input logic [1:0] y,
                                           input logic       cin);
    add_slice = {1'b0, x} + {1'b0, y} + {2'b00, cin};
  endfunction

  assign accept     = start_valid && (state_q == IDLE);
  assign last_chunk = (cnt == LAST_CHUNK);
  assign slice      = add_slice(a_sh[1:0], b_sh[1:0], carry);
  // New chunk enters at the top; after CHUNKS shifts the first chunk sits at bit 0.
  assign sum_shift  = {slice[1:0], sum_q[WIDTH-1:0]} >> 2;

`ifdef ADD_SEQ_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_init = sub;
`else
  assign b_load     = b;
  assign carry_init = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid) state_d = RUN;
      RUN:     if (last_chunk)  state_d = DONE;
      DONE:    if (res_ready)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Carry, chunk counter and result register; cleared on reset and on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry <= 1'b0;
      cnt   <= '0;
      sum_q <= '0;
    end else if (accept) begin
      carry <= carry_init;
      cnt   <= '0;
      sum_q <= '0;
    end else if (state_q == RUN) begin
      carry              <= slice[2];
      cnt                <= cnt + CNT_W'(1);
      sum_q[WIDTH-1:0]   <= sum_shift[WIDTH-1:0];
      if (last_chunk)
        sum_q[WIDTH]     <= slice[2];
    end
  end

  // Operand shift registers; only meaningful between accept and DONE.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= a;
      b_sh <= b_load;
    end else if (state_q == RUN) begin
      a_sh <= a_sh >> 2;
      b_sh <= b_sh >> 2;
    end
  end

  // Output decode from state.
  always_comb begin
    start_ready = (state_q == IDLE) && !rst;
    res_valid   = (state_q == DONE);
    busy        = (state_q != IDLE);
    sum         = sum_q;
  end

endmodule
